writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 150 +++++++++++++++
 tb/tb_writeback_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and FIFO-buffered
// long-latency (LSU) results onto the integer and FP register file write
// ports. Write ports are registered; commit and stall counters are kept here.
module writeback_arbiter #(
  parameter int DATA_WIDTH     = 64,
  parameter int LSU_FIFO_DEPTH = 4,
  localparam int PW = $clog2(LSU_FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [4:0]            alu_rd_addr,
  input  logic [DATA_WIDTH-1:0] alu_rd_data,
  input  logic                  alu_is_fp,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [4:0]            lsu_rd_addr,
  input  logic [DATA_WIDTH-1:0] lsu_rd_data,
  input  logic                  lsu_is_fp,
  output logic                  lsu_ready,
  output logic                  int_rd_write,
  output logic [4:0]            int_rd_addr,
  output logic [DATA_WIDTH-1:0] int_rd_data,
  output logic                  fp_rd_write,
  output logic [4:0]            fp_rd_addr,
  output logic [DATA_WIDTH-1:0] fp_rd_data,
  output logic [CW-1:0]         fifo_count,
  output logic [31:0]           wb_count,
  output logic [15:0]           alu_stall_cycles
);

  logic [4:0]            q_addr [LSU_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [LSU_FIFO_DEPTH];
  logic                  q_fp   [LSU_FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;

  logic                  full, head_vld, head_fp;
  logic [4:0]            head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  alu_go, lsu_push, head_go;

  logic                  int_go, fp_go, int_we, fp_we;
  logic [4:0]            int_addr_n, fp_addr_n;
  logic [DATA_WIDTH-1:0] int_data_n, fp_data_n;

  // Only entries pushed on earlier edges are counted, so a new entry cannot
  // be granted in the cycle it arrives.
  assign full      = (fifo_count == CW'(LSU_FIFO_DEPTH));
  assign head_vld  = (fifo_count != '0);
  assign head_fp   = q_fp[rd_ptr];
  assign head_addr = q_addr[rd_ptr];
  assign head_data = q_data[rd_ptr];

  // A full FIFO takes priority on its head's file; otherwise the ALU wins.
  assign lsu_ready = !reset && !full;
  assign alu_ready = !reset && !(full && (head_fp == alu_is_fp));
  assign alu_go    = alu_valid && alu_ready;
  assign lsu_push  = lsu_valid && lsu_ready;
  assign head_go   = !reset && head_vld &&
                     (full || !alu_valid || (alu_is_fp != head_fp));

  // Route each winner to its file; integer x0 is granted but never written.
  always_comb begin
    int_go     = 1'b0;
    int_addr_n = alu_rd_addr;
    int_data_n = alu_rd_data;
    fp_go      = 1'b0;
    fp_addr_n  = alu_rd_addr;
    fp_data_n  = alu_rd_data;
    if (alu_go && !alu_is_fp) begin
      int_go = 1'b1;
    end else if (head_go && !head_fp) begin
      int_go     = 1'b1;
      int_addr_n = head_addr;
      int_data_n = head_data;
    end
    if (alu_go && alu_is_fp) begin
      fp_go = 1'b1;
    end else if (head_go && head_fp) begin
      fp_go     = 1'b1;
      fp_addr_n = head_addr;
      fp_data_n = head_data;
    end
    int_we = int_go && (int_addr_n != 5'd0);
    fp_we  = fp_go;
  end

  // FIFO storage; contents are don't-care until counted, so no reset.
  always_ff @(posedge clk) begin
    if (lsu_push) begin
      q_addr[wr_ptr] <= lsu_rd_addr;
      q_data[wr_ptr] <= lsu_rd_data;
      q_fp[wr_ptr]   <= lsu_is_fp;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (lsu_push) wr_ptr <= wr_ptr + PW'(1);
      if (head_go)  rd_ptr <= rd_ptr + PW'(1);
      case ({lsu_push, head_go})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Registered write ports: strobes last one cycle, addr/data hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      int_rd_write <= 1'b0;
      int_rd_addr  <= '0;
      int_rd_data  <= '0;
      fp_rd_write  <= 1'b0;
      fp_rd_addr   <= '0;
      fp_rd_data   <= '0;
    end else begin
      int_rd_write <= int_we;
      fp_rd_write  <= fp_we;
      if (int_we) begin
        int_rd_addr <= int_addr_n;
        int_rd_data <= int_data_n;
      end
      if (fp_we) begin
        fp_rd_addr <= fp_addr_n;
        fp_rd_data <= fp_data_n;
      end
    end
  end

  // Commit counter (wrapping) and ALU stall counter (saturating).
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_count         <= '0;
      alu_stall_cycles <= '0;
    end else begin
      wb_count <= wb_count + 32'(int_we) + 32'(fp_we);
      if (alu_valid && !alu_ready && (alu_stall_cycles != 16'hFFFF))
        alu_stall_cycles <= alu_stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: per-cycle vector table with expected
// ready/occupancy, plus a scoreboard of LSU results popped in order as
// register-file strobes appear.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_is_fp, alu_ready;
  logic [4:0]  alu_rd_addr;
  logic [63:0] alu_rd_data;
  logic        lsu_valid, lsu_is_fp, lsu_ready;
  logic [4:0]  lsu_rd_addr;
  logic [63:0] lsu_rd_data;
  logic        int_rd_write, fp_rd_write;
  logic [4:0]  int_rd_addr, fp_rd_addr;
  logic [63:0] int_rd_data, fp_rd_data;
  logic [2:0]  fifo_count;
  logic [31:0] wb_count;
  logic [15:0] alu_stall_cycles;

  writeback_arbiter #(.DATA_WIDTH(64), .LSU_FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd_addr(alu_rd_addr), .alu_rd_data(alu_rd_data),
    .alu_is_fp(alu_is_fp), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd_addr(lsu_rd_addr), .lsu_rd_data(lsu_rd_data),
    .lsu_is_fp(lsu_is_fp), .lsu_ready(lsu_ready),
    .int_rd_write(int_rd_write), .int_rd_addr(int_rd_addr), .int_rd_data(int_rd_data),
    .fp_rd_write(fp_rd_write), .fp_rd_addr(fp_rd_addr), .fp_rd_data(fp_rd_data),
    .fifo_count(fifo_count), .wb_count(wb_count), .alu_stall_cycles(alu_stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rst;
    bit        av;  bit [4:0] aa; bit afp; logic [63:0] ad;
    bit        lv;  bit [4:0] la; bit lfp; logic [63:0] ld;
    bit        chk; bit ar; bit lr; bit [2:0] cnt;
  } vec_t;

  typedef struct {
    bit          fp;
    bit [4:0]    a;
    logic [63:0] d;
  } wr_t;

  vec_t vt[$];
  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int unsigned m_wb;
  int unsigned m_stall;
  logic [4:0]  m_int_a, m_fp_a;
  logic [63:0] m_int_d, m_fp_d;

  function automatic vec_t V(bit rst, bit av, bit [4:0] aa, bit afp, logic [63:0] ad,
                             bit lv, bit [4:0] la, bit lfp, logic [63:0] ld,
                             bit chk, bit ar, bit lr, bit [2:0] cnt);
    vec_t t;
    t.rst = rst; t.av = av; t.aa = aa; t.afp = afp; t.ad = ad;
    t.lv = lv; t.la = la; t.lfp = lfp; t.ld = ld;
    t.chk = chk; t.ar = ar; t.lr = lr; t.cnt = cnt;
    return t;
  endfunction

  function automatic vec_t IDLE(bit [2:0] cnt);
    return V(0, 0,0,0,0, 0,0,0,0, 1,1,1,cnt);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare one file's write port against the ALU expectation or the scoreboard head.
  task automatic check_file(input bit fp, input bit alu_exp, input wr_t alu_e,
                            input logic w, input logic [4:0] a, input logic [63:0] d);
    wr_t   e;
    bit    have = 0;
    string nm = fp ? "fp" : "int";
    if (alu_exp) begin
      e = alu_e; have = 1;
    end else if (w === 1'b1) begin
      if (exp_q.size() == 0 || exp_q[0].fp != fp) begin
        checks++; errors++;
        $display("FAIL %s_unexpected_write: got addr %0d data %0h, no result pending", nm, a, d);
        return;
      end
      e = exp_q.pop_front(); have = 1;
    end
    if (have) begin
      chk({nm, "_write"}, 64'(w), 64'd1);
      chk({nm, "_addr"},  64'(a), 64'(e.a));
      chk({nm, "_data"},  d, e.d);
      m_wb++;
      if (fp) begin m_fp_a = e.a; m_fp_d = e.d; end
      else    begin m_int_a = e.a; m_int_d = e.d; end
    end else begin
      chk({nm, "_idle_write"}, 64'(w), 64'd0);
      chk({nm, "_hold_addr"},  64'(a), fp ? 64'(m_fp_a) : 64'(m_int_a));
      chk({nm, "_hold_data"},  d, fp ? m_fp_d : m_int_d);
    end
  endtask

  // One clock cycle: drive, check readies/occupancy, edge, check outputs.
  task automatic step(input vec_t t);
    bit  acc_a, acc_l;
    wr_t ae, none;
    none = '{fp: 0, a: 0, d: 0};
    reset = t.rst;
    alu_valid = t.av; alu_rd_addr = t.aa; alu_is_fp = t.afp; alu_rd_data = t.ad;
    lsu_valid = t.lv; lsu_rd_addr = t.la; lsu_is_fp = t.lfp; lsu_rd_data = t.ld;
    #1;
    if (t.chk) begin
      chk("alu_ready",  64'(alu_ready),  64'(t.ar));
      chk("lsu_ready",  64'(lsu_ready),  64'(t.lr));
      chk("fifo_count", 64'(fifo_count), 64'(t.cnt));
    end
    acc_a = t.av && (alu_ready === 1'b1);
    acc_l = t.lv && (lsu_ready === 1'b1);
    if (!t.rst && t.av && alu_ready === 1'b0 && m_stall != 32'hFFFF) m_stall++;
    if (acc_l && !(!t.lfp && t.la == 5'd0))
      exp_q.push_back('{fp: t.lfp, a: t.la, d: t.ld});
    ae = '{fp: t.afp, a: t.aa, d: t.ad};
    @(posedge clk); #1;
    if (t.rst) begin
      chk("rst_int_write", 64'(int_rd_write), 64'd0);
      chk("rst_fp_write",  64'(fp_rd_write),  64'd0);
      chk("rst_int_addr",  64'(int_rd_addr),  64'd0);
      chk("rst_int_data",  int_rd_data,       64'd0);
      chk("rst_fp_addr",   64'(fp_rd_addr),   64'd0);
      chk("rst_fp_data",   fp_rd_data,        64'd0);
      chk("rst_fifo_count",64'(fifo_count),   64'd0);
      chk("rst_wb_count",  64'(wb_count),     64'd0);
      chk("rst_stall",     64'(alu_stall_cycles), 64'd0);
      exp_q.delete();
      m_wb = 0; m_stall = 0;
      m_int_a = 0; m_int_d = 0; m_fp_a = 0; m_fp_d = 0;
    end else begin
      check_file(0, acc_a && !t.afp && t.aa != 5'd0, acc_a ? ae : none,
                 int_rd_write, int_rd_addr, int_rd_data);
      check_file(1, acc_a && t.afp, acc_a ? ae : none,
                 fp_rd_write, fp_rd_addr, fp_rd_data);
      chk("wb_count",         64'(wb_count),         64'(m_wb));
      chk("alu_stall_cycles", 64'(alu_stall_cycles), 64'(m_stall));
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1; alu_valid = 0; alu_rd_addr = 0; alu_rd_data = 0; alu_is_fp = 0;
    lsu_valid = 0; lsu_rd_addr = 0; lsu_rd_data = 0; lsu_is_fp = 0;
    m_wb = 0; m_stall = 0; m_int_a = 0; m_int_d = 0; m_fp_a = 0; m_fp_d = 0;

    //            rst av aa afp ad        lv la lfp ld        chk ar lr cnt
    vt.push_back(V(1, 0, 0, 0, 0,         0, 0, 0, 0,         0, 0, 0, 0));
    vt.push_back(V(1, 0, 0, 0, 0,         0, 0, 0, 0,         1, 0, 0, 0));
    // ALU int x5 and a single LSU int x7
    vt.push_back(V(0, 1, 5, 0, 64'hA5,    0, 0, 0, 0,         1, 1, 1, 0));
    vt.push_back(IDLE(0));
    vt.push_back(V(0, 0, 0, 0, 0,         1, 7, 0, 64'h11,    1, 1, 1, 0));
    vt.push_back(IDLE(1));
    vt.push_back(IDLE(0));
    // ALU int every cycle while the FIFO fills, then head forces a stall
    vt.push_back(V(0, 1, 1, 0, 64'h101,   1, 10, 0, 64'h210,  1, 1, 1, 0));
    vt.push_back(V(0, 1, 2, 0, 64'h102,   1, 11, 0, 64'h211,  1, 1, 1, 1));
    vt.push_back(V(0, 1, 3, 0, 64'h103,   1, 12, 0, 64'h212,  1, 1, 1, 2));
    vt.push_back(V(0, 1, 4, 0, 64'h104,   1, 13, 0, 64'h213,  1, 1, 1, 3));
    vt.push_back(V(0, 1, 6, 0, 64'h106,   1, 14, 0, 64'h214,  1, 0, 0, 4));
    vt.push_back(V(0, 1, 6, 0, 64'h106,   1, 14, 0, 64'h214,  1, 1, 1, 3));
    vt.push_back(V(0, 1, 8, 0, 64'h108,   0, 0, 0, 0,         1, 0, 0, 4));
    vt.push_back(V(0, 1, 8, 0, 64'h108,   0, 0, 0, 0,         1, 1, 1, 3));
    vt.push_back(IDLE(3));
    vt.push_back(IDLE(2));
    vt.push_back(IDLE(1));
    vt.push_back(IDLE(0));
    // ALU fp f3 alongside FIFO head int x9, then FP f0
    vt.push_back(V(0, 0, 0, 0, 0,         1, 9, 0, 64'h99,    1, 1, 1, 0));
    vt.push_back(V(0, 1, 3, 1, 64'h33F,   0, 0, 0, 0,         1, 1, 1, 1));
    vt.push_back(IDLE(0));
    vt.push_back(V(0, 1, 0, 1, 64'hF0,    0, 0, 0, 0,         1, 1, 1, 0));
    // FP head vs ALU int (parallel, push+pop same edge), then ALU fp wins
    vt.push_back(V(0, 1, 1, 0, 64'h201,   1, 1, 1, 64'h301,   1, 1, 1, 0));
    vt.push_back(V(0, 1, 2, 0, 64'h202,   1, 2, 1, 64'h302,   1, 1, 1, 1));
    vt.push_back(V(0, 1, 4, 1, 64'h304,   1, 5, 1, 64'h305,   1, 1, 1, 1));
    vt.push_back(IDLE(2));
    vt.push_back(IDLE(1));
    vt.push_back(IDLE(0));
    // integer x0 from ALU and from LSU: consumed, never written
    vt.push_back(V(0, 1, 0, 0, 64'hFF,    0, 0, 0, 0,         1, 1, 1, 0));
    vt.push_back(V(0, 0, 0, 0, 0,         1, 0, 0, 64'hEE,    1, 1, 1, 0));
    vt.push_back(IDLE(1));
    vt.push_back(IDLE(0));

    foreach (vt[i]) step(vt[i]);
    chk("drain_after_table", 64'(exp_q.size()), 64'd0);

    // Reset with three entries queued and an ALU write on the port
    step(V(0, 1, 1, 0, 64'h401, 1, 20, 0, 64'h420, 1, 1, 1, 0));
    step(V(0, 1, 2, 0, 64'h402, 1, 21, 0, 64'h421, 1, 1, 1, 1));
    step(V(0, 1, 3, 0, 64'h403, 1, 22, 0, 64'h422, 1, 1, 1, 2));
    chk("pending_int_write", 64'(int_rd_write), 64'd1);
    step(V(1, 1, 3, 0, 64'h403, 1, 23, 0, 64'h423, 1, 0, 0, 3));
    // first edge out of reset accepts immediately; stale entries never appear
    step(V(0, 1, 9, 0, 64'h509, 0, 0, 0, 0, 1, 1, 1, 0));
    for (int k = 0; k < 4; k++) step(IDLE(0));
    chk("drain_after_reset", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop if the stimulus ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout: got no finish by 20000 expected earlier");
    $fatal(1);
  end

endmodule
